// File: rtl/zen_core_if.sv
// Fetch-to-decode and refill-memory handshake bundle for zen_core.
// master = fetch unit side, slave = decode/memory side.
interface zen_core_if;
  logic        out_valid;
  logic [31:0] out_bits_inst;
  logic [31:0] out_bits_pc;
  logic        out_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_bits_rdata;

  modport master (
    output out_valid,
    output out_bits_inst,
    output out_bits_pc,
    input  out_ready,
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_bits_rdata
  );

  modport slave (
    input  out_valid,
    input  out_bits_inst,
    input  out_bits_pc,
    output out_ready,
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_bits_rdata
  );
endinterface

// File: rtl/zen_core.sv
// Zen fetch front end: PC gen, direct-mapped I-cache, output register.
// Optional hit/miss counters enabled by ZEN_ICACHE_PERF_EN.
module zen_core #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          LINES    = 16,
  parameter int          INDEX_W  = $clog2(LINES)
) (
  input  logic        clock,
  input  logic        reset,
  zen_core_if.master  bus,
  input  logic        isFlush,
  input  logic [31:0] correctedPC,
  input  logic        fencei_valid,
  input  logic        fencei_bits_is_fencei
`ifdef ZEN_ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  localparam int TAG_W = 30 - INDEX_W;

  localparam logic [1:0] S_LOOKUP    = 2'd0;
  localparam logic [1:0] S_MISS_REQ  = 2'd1;
  localparam logic [1:0] S_MISS_WAIT = 2'd2;
  localparam logic [1:0] S_DROP      = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [31:0]      pc;
  logic [LINES-1:0] line_v;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES];

  logic             out_valid;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [31:0]      req_addr;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic hit, free, fence, kill;
  logic do_hit, do_miss, req_hs, fill;

  assign idx   = pc[2 +: INDEX_W];
  assign tag   = pc[31 -: TAG_W];
  assign hit   = line_v[idx] && (tag_q[idx] == tag);
  assign free  = !out_valid || bus.out_ready;
  assign fence = fencei_valid && fencei_bits_is_fencei;
  assign kill  = isFlush || fence;

  assign do_hit  = (state == S_LOOKUP) && free && hit && !isFlush;
  assign do_miss = (state == S_LOOKUP) && free && !hit && !isFlush;
  assign req_hs  = (state == S_MISS_REQ) && bus.mem_req_ready;
  assign fill    = (state == S_MISS_WAIT) && bus.mem_resp_valid && !kill;

  always_comb begin
    state_d = state;
    unique case (state)
      S_LOOKUP: begin
        if (do_miss) state_d = S_MISS_REQ;
      end
      S_MISS_REQ: begin
        if (req_hs) state_d = kill ? S_DROP : S_MISS_WAIT;
        else if (kill) state_d = S_LOOKUP;
      end
      S_MISS_WAIT: begin
        if (bus.mem_resp_valid) state_d = S_LOOKUP;
        else if (kill) state_d = S_DROP;
      end
      S_DROP: begin
        if (bus.mem_resp_valid) state_d = S_LOOKUP;
      end
      default: state_d = S_LOOKUP;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_LOOKUP;
      pc       <= RESET_PC;
      line_v   <= '0;
      req_addr <= '0;
    end else begin
      state <= state_d;
      if (isFlush) pc <= correctedPC & ~32'd3;
      else if (do_hit) pc <= pc + 32'd4;
      // fence.i wins over a fill landing in the same cycle
      if (fence) line_v <= '0;
      else if (fill) line_v[idx] <= 1'b1;
      if (do_miss) req_addr <= pc & ~32'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.mem_resp_bits_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (isFlush) begin
      out_valid <= 1'b0;
    end else if (do_hit) begin
      out_valid <= 1'b1;
      out_inst  <= data_q[idx];
      out_pc    <= pc;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid;
  assign bus.out_bits_inst = out_inst;
  assign bus.out_bits_pc   = out_pc;
  assign bus.mem_req_valid = (state == S_MISS_REQ);
  assign bus.mem_req_addr  = req_addr;

`ifdef ZEN_ICACHE_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (do_hit)  perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      if (do_miss) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_zen_core.sv
// Directed plus randomized bench for zen_core against a
// transaction-level fetch-stream and cache-contents model.
module tb_zen_core;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          LINES    = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        isFlush = 1'b0;
  logic [31:0] correctedPC = '0;
  logic        fencei_valid = 1'b0;
  logic        fencei_is = 1'b0;

  zen_core_if bus();

  zen_core #(.RESET_PC(RESET_PC), .LINES(LINES)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master),
    .isFlush(isFlush),
    .correctedPC(correctedPC),
    .fencei_valid(fencei_valid),
    .fencei_bits_is_fencei(fencei_is)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int deliveries = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] model_line [LINES];
  logic        model_v [LINES];
  logic        pending = 1'b0;
  logic        live = 1'b0;
  int          wait_cnt = 0;
  int          resp_lat = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] memf(logic [31:0] a);
    return ((a ^ 32'h8000_0000) * 32'h9E37_79B1) + 32'h13;
  endfunction

  function automatic int lidx(logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic logic cached(logic [31:0] a);
    return model_v[lidx(a)] && (model_line[lidx(a)] == (a & ~32'd3));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) model_v[i] = 1'b0;
  endtask

  // One clock: sample before the edge, update model, drive responder after.
  task automatic cyc();
    logic req_hs, out_hs, fl, fe, rsp, rstall, ohold;
    logic [31:0] raddr, opc, oinst;
    req_hs = bus.mem_req_valid && bus.mem_req_ready;
    raddr  = bus.mem_req_addr;
    out_hs = bus.out_valid && bus.out_ready;
    opc    = bus.out_bits_pc;
    oinst  = bus.out_bits_inst;
    fl     = isFlush;
    fe     = fencei_valid && fencei_is;
    rsp    = bus.mem_resp_valid;
    rstall = reset && bus.mem_req_valid && !bus.mem_req_ready && !fl && !fe;
    ohold  = reset && bus.out_valid && !bus.out_ready && !fl;
    if (out_hs && !fl) begin
      chk("deliver_pc", opc, exp_pc);
      chk("deliver_inst", oinst, memf(opc));
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end
    if (fl) exp_pc = correctedPC & ~32'd3;
    if (req_hs) begin
      chk("req_is_miss", {31'd0, cached(raddr)}, 32'd0);
      chk("req_aligned", {30'd0, raddr[1:0]}, 32'd0);
    end
    if (rsp) begin
      if (live && !fl && !fe) begin
        model_line[lidx(pend_addr)] = pend_addr;
        model_v[lidx(pend_addr)] = 1'b1;
      end
      live = 1'b0;
    end else if (fl || fe) begin
      live = 1'b0;
    end
    if (fe) clear_model();
    if (req_hs) live = !(fl || fe);
    @(posedge clock);
    #1;
    if (fl) chk("flush_kills_out", {31'd0, bus.out_valid}, 32'd0);
    if (rstall) begin
      chk("req_hold_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      chk("req_hold_addr", bus.mem_req_addr, raddr);
    end
    if (ohold) begin
      chk("out_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("out_hold_pc", bus.out_bits_pc, opc);
      chk("out_hold_inst", bus.out_bits_inst, oinst);
    end
    bus.mem_resp_valid = 1'b0;
    if (req_hs) begin
      pending   = 1'b1;
      pend_addr = raddr;
      wait_cnt  = resp_lat;
    end
    if (pending) begin
      if (wait_cnt == 0) begin
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_bits_rdata = memf(pend_addr);
        pending = 1'b0;
      end else begin
        wait_cnt--;
      end
    end
  endtask

  task automatic flush_to(logic [31:0] a);
    isFlush = 1'b1;
    correctedPC = a;
    cyc();
    isFlush = 1'b0;
  endtask

  task automatic wait_req(string tag, int n);
    for (int k = 0; k < n && !bus.mem_req_valid; k++) cyc();
    chk(tag, {31'd0, bus.mem_req_valid}, 32'd1);
  endtask

  task automatic wait_out(string tag, int n);
    for (int k = 0; k < n && !bus.out_valid; k++) cyc();
    chk(tag, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_inst"}, bus.out_bits_inst, 32'd0);
    chk({tag, "_pc"}, bus.out_bits_pc, 32'd0);
    chk({tag, "_req_valid"}, {31'd0, bus.mem_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, bus.mem_req_addr, 32'd0);
  endtask

  initial begin
    int d0;
    logic [31:0] hold_inst;
    bus.out_ready = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_bits_rdata = '0;
    clear_model();

    // reset and first cold miss
    #2 reset = 1'b0;
    repeat (3) cyc();
    chk_reset_outs("reset");
    reset = 1'b1;
    exp_pc = RESET_PC;
    bus.out_ready = 1'b1;
    bus.mem_req_ready = 1'b1;
    wait_req("t1_req_seen", 10);
    chk("t1_req_addr", bus.mem_req_addr, 32'h8000_0000);
    wait_out("t1_out_seen", 10);
    chk("t1_inst", bus.out_bits_inst, 32'h0000_0013);
    chk("t1_pc", bus.out_bits_pc, 32'h8000_0000);
    wait_req("t1_next_seen", 10);
    chk("t1_next_addr", bus.mem_req_addr, 32'h8000_0004);

    // cold fill through 0x0C, then replay from cache
    for (int k = 0; k < 100 && exp_pc != 32'h8000_0010; k++) cyc();
    chk("t2_filled", exp_pc, 32'h8000_0010);
    bus.mem_req_ready = 1'b0;
    repeat (2) cyc();
    flush_to(RESET_PC);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_hit_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t2_hit_pc", bus.out_bits_pc, RESET_PC + 32'(4 * i));
      chk("t2_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    end

    // backpressure
    bus.out_ready = 1'b0;
    flush_to(RESET_PC);
    cyc();
    chk("t3_first", bus.out_bits_pc, RESET_PC);
    hold_inst = bus.out_bits_inst;
    repeat (3) cyc();
    chk("t3_stall_pc", bus.out_bits_pc, RESET_PC);
    chk("t3_stall_inst", bus.out_bits_inst, hold_inst);
    bus.out_ready = 1'b1;
    d0 = deliveries;
    repeat (4) cyc();
    chk("t3_resume_count", 32'(deliveries - d0), 32'd4);

    // flush during MISS_WAIT, unaligned target
    resp_lat = 3;
    bus.mem_req_ready = 1'b1;
    wait_req("t4_req_seen", 10);
    chk("t4_req_addr", bus.mem_req_addr, 32'h8000_0010);
    cyc();
    flush_to(32'h1234_5673);
    chk("t4_killed", {31'd0, bus.out_valid}, 32'd0);
    wait_req("t4_redir_seen", 20);
    chk("t4_redir_addr", bus.mem_req_addr, 32'h1234_5670);
    resp_lat = 0;
    wait_out("t4_out_seen", 20);
    chk("t4_out_pc", bus.out_bits_pc, 32'h1234_5670);

    // fence.i invalidation vs unqualified strobe
    bus.out_ready = 1'b0;
    flush_to(RESET_PC);
    wait_out("t5_hit_seen", 20);
    chk("t5_hit_pc", bus.out_bits_pc, RESET_PC);
    fencei_valid = 1'b1;
    fencei_is = 1'b1;
    cyc();
    fencei_valid = 1'b0;
    fencei_is = 1'b0;
    chk("t5_out_survives", {31'd0, bus.out_valid}, 32'd1);
    flush_to(RESET_PC);
    wait_req("t5_refetch_seen", 10);
    chk("t5_refetch_addr", bus.mem_req_addr, RESET_PC);
    wait_out("t5_fill_seen", 20);
    chk("t5_fill_pc", bus.out_bits_pc, RESET_PC);
    fencei_valid = 1'b1;
    cyc();
    fencei_valid = 1'b0;
    flush_to(RESET_PC);
    cyc();
    chk("t5_nofence_hit", {31'd0, bus.out_valid}, 32'd1);
    chk("t5_nofence_noreq", {31'd0, bus.mem_req_valid}, 32'd0);

    // async reset in MISS_WAIT
    bus.out_ready = 1'b1;
    resp_lat = 5;
    flush_to(32'h8000_0040);
    wait_req("t6_req_seen", 10);
    chk("t6_req_addr", bus.mem_req_addr, 32'h8000_0040);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk_reset_outs("t6_async");
    pending = 1'b0;
    live = 1'b0;
    bus.mem_resp_valid = 1'b0;
    clear_model();
    repeat (2) cyc();
    reset = 1'b1;
    exp_pc = RESET_PC;
    resp_lat = 0;
    wait_req("t6_after_seen", 10);
    chk("t6_after_addr", bus.mem_req_addr, RESET_PC);

    // randomized traffic
    d0 = deliveries;
    for (int c = 0; c < 2500; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.mem_req_ready = ($urandom_range(0, 2) != 0);
      resp_lat = int'($urandom_range(0, 2));
      isFlush = ($urandom_range(0, 24) == 0);
      correctedPC = RESET_PC + 32'($urandom_range(0, 47) * 4)
                  + 32'($urandom_range(0, 3));
      fencei_valid = ($urandom_range(0, 39) == 0);
      fencei_is = ($urandom_range(0, 1) == 1);
      cyc();
      isFlush = 1'b0;
      fencei_valid = 1'b0;
    end
    chk("rand_progress", {31'd0, (deliveries - d0) > 50}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/zen_core.md
Name: zen_core

Overview:
- Instruction-fetch front end of the Zen core: PC generator, direct-mapped instruction cache and a one-entry output register.
- Delivers {inst, pc} to decode over a valid/ready interface.
- Accepts branch redirects from the backend (isFlush/correctedPC) and fence.i cache invalidation.
- Refills from a single-word memory port.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset
LINES, 16, cache lines (power of 2, ≥2); one 32-bit word per line
INDEX_W, log2(LINES), index width; tag = pc[31:2+INDEX_W]

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
out_valid  out  1  fetched instruction available
out_bits_inst  out  32  instruction word
out_bits_pc  out  32  PC of that instruction
out_ready  in  1  decode accepts instruction
isFlush  in  1  redirect fetch, kill in-flight work
correctedPC  in  32  redirect target (valid with isFlush)
fencei_valid  in  1  fence.i event strobe
fencei_bits_is_fencei  in  1  qualifier; invalidate only when both high
mem_req_valid  out  1  refill request
mem_req_addr  out  32  word-aligned refill address ({pc[31:2],2'b00})
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  refill data returned (one cycle)
mem_resp_bits_rdata  in  32  refill word

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; all line valid bits=0; state=LOOKUP; out_valid=0.
  - out_bits_inst=0, out_bits_pc=0, mem_req_valid=0, mem_req_addr=0.
- Output register "free" = !out_valid || out_ready.
- States: LOOKUP, MISS_REQ, MISS_WAIT, DROP.
- LOOKUP, free, hit (valid[idx] && tag match):
  - load out reg with {data[idx], pc}; out_valid=1 next cycle; pc+=4 (wraps mod 2^32).
  - Hit latency: 1 cycle.
  - Back-to-back hits sustain one instruction per cycle while out_ready=1.
- LOOKUP, miss: → MISS_REQ. Lookup stalls while not free (pc held).
- MISS_REQ:
  - mem_req_valid=1, addr stable until mem_req_ready.
  - On handshake → MISS_WAIT.
- MISS_WAIT:
  - on mem_resp_valid: write data/tag, set valid[idx], → LOOKUP.
  - The re-lookup then hits (miss-to-out_valid = handshake + response + 2 cycles).
- DROP: wait for mem_resp_valid, discard data (no fill), → LOOKUP.
- isFlush=1 (highest priority, any state):
  - next cycle pc=correctedPC[31:2]<<2 and out_valid=0 (pending output killed even if out_ready=1).
  - LOOKUP/MISS_REQ without handshake → LOOKUP.
  - MISS_REQ with handshake same cycle, or MISS_WAIT → DROP.
  - MISS_WAIT with mem_resp_valid same cycle → LOOKUP, no fill.
- fencei_valid && fencei_bits_is_fencei:
  - clears all valid bits next cycle.
  - In MISS_REQ/MISS_WAIT the miss is converted to discard-and-refetch (same transitions as flush, pc unchanged).
  - The out register is not killed.
  - A fill completing the same cycle is not written.
- Flush and fence.i in the same cycle: both apply.
- Out register holds stable data while out_valid && !out_ready.
- mem_resp_valid in LOOKUP/MISS_REQ is ignored.
- Unaligned correctedPC: low 2 bits forced to 0.

Optional Feature:
- Macro ZEN_ICACHE_PERF_EN.
- Defined: adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - Hit counter increments on each LOOKUP hit that loads the out reg.
  - Miss counter increments on each LOOKUP→MISS_REQ.
  - Both reset to 0, wrap at 2^32, unaffected by flush/fence.i.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then release, mem_req_ready=1, memory returns 32'h0000_0013 one cycle after request → mem_req_addr=32'h8000_0000; out_valid with inst=0x13, pc=0x8000_0000; next fetch requests 0x8000_0004.
- Cold-fill 0x8000_0000..0x8000_000C, then flush to 0x8000_0000 with out_ready=1 → four consecutive cycles of out_valid with pc 0x..00,04,08,0C; no mem requests.
- out_ready=0 for 3 cycles with out_valid=1 → inst/pc stable; pc not advanced; resumes without loss or duplication.
- isFlush with correctedPC=32'h1234_5673 while in MISS_WAIT → next cycle out_valid=0; late response discarded; next request addr=32'h1234_5670.
- Fill line 0x8000_0000, pulse fencei_valid+is_fencei, flush to 0x8000_0000 → new miss request to 0x8000_0000; fencei_valid alone (is_fencei=0) → hit, no request.
- Assert reset mid-MISS_WAIT → outputs return to reset values immediately; next request addr=RESET_PC.
